// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the combinational instruction ROM,
// buffers {pc, instr} pairs and hands them to decode over a valid/ready handshake.
// Fetch stops with a fault on a misaligned redirect target or when the PC leaves
// the ROM range. A redirect clears the fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_WORDS = 32,
  parameter int unsigned DEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int unsigned   PtrW    = $clog2(DEPTH);
  localparam int unsigned   CntW    = PtrW + 1;
  localparam logic [31:0]   PcLimit = 32'(ROM_WORDS * 4);
  localparam logic [CntW-1:0] CntMax = CntW'(DEPTH);

  typedef enum logic [0:0] {StRun, StFault} state_e;

  state_e          state_q;
  logic [31:0]     pc_q;
  logic [31:0]     fault_pc_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic [31:0]     buf_pc_q    [DEPTH];
  logic [31:0]     buf_instr_q [DEPTH];

  logic pop;
  logic push;
  logic in_range;

  // Handshake and push qualification; a pop frees a slot in the same cycle.
  always_comb begin
    pop      = (count_q != '0) && out_ready;
    in_range = pc_q < PcLimit;
    push     = (state_q == StRun) && in_range && ((count_q < CntMax) || pop);
  end

  // PC, buffer pointers/occupancy and run/fault state; redirect overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      fault_pc_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else if (redirect_valid) begin
      // Flush: any same-cycle push is dropped, a same-cycle pop was already consumed.
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pc_q     <= redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        state_q    <= StFault;
        fault_pc_q <= redirect_pc;
      end else begin
        state_q <= StRun;
      end
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
        pc_q     <= pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
      if ((state_q == StRun) && !in_range) begin
        state_q    <= StFault;
        fault_pc_q <= pc_q;
      end
    end
  end

  // Buffer storage; contents are meaningless while the slot is not occupied.
  always_ff @(posedge clk) begin
    if (push && !redirect_valid) begin
      buf_pc_q[wr_ptr_q]    <= pc_q;
      buf_instr_q[wr_ptr_q] <= imem_data;
    end
  end

  // Outputs are taken straight from registers.
  always_comb begin
    imem_addr = pc_q;
    out_valid = count_q != '0;
    out_pc    = buf_pc_q[rd_ptr_q];
    out_instr = buf_instr_q[rd_ptr_q];
    fault     = state_q == StFault;
    fault_pc  = fault_pc_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-based reference model of the fetch
// buffer is stepped once per clock and compared with every DUT output.
module tb_fetch_unit;

  localparam int unsigned ROM_WORDS = 32;
  localparam int unsigned DEPTH     = 2;
  localparam logic [31:0] ROM_BYTES = 32'(ROM_WORDS * 4);

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;

  logic [31:0] rom [ROM_WORDS];

  // Reference model state
  logic [63:0] q[$];
  logic [31:0] m_pc;
  logic        m_fault;
  logic [31:0] m_fpc;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .ROM_WORDS(ROM_WORDS),
    .DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .fault         (fault),
    .fault_pc      (fault_pc)
  );

  always #5 clk = ~clk;

  // Combinational ROM; out-of-range reads return junk that must never be buffered.
  always_comb begin
    if (imem_addr < ROM_BYTES) imem_data = rom[imem_addr[6:2]];
    else                       imem_data = 32'hBAD0_0000 ^ imem_addr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc    = 32'h0;
    m_fault = 1'b0;
    m_fpc   = 32'h0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, q.size() != 0});
    if (q.size() != 0) begin
      check({tag, ".out_pc"}, out_pc, q[0][63:32]);
      check({tag, ".out_instr"}, out_instr, q[0][31:0]);
    end
    check({tag, ".fault"}, {31'b0, fault}, {31'b0, m_fault});
    check({tag, ".fault_pc"}, fault_pc, m_fpc);
    check({tag, ".imem_addr"}, imem_addr, m_pc);
  endtask

  // One clock: drive inputs, advance the model over the edge, compare after it.
  task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy, input string tag);
    logic pop;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(posedge clk);
    pop = (q.size() != 0) && rdy;
    if (rv) begin
      q.delete();
      m_pc = rpc;
      if (rpc[1:0] != 2'b00) begin
        m_fault = 1'b1;
        m_fpc   = rpc;
      end else begin
        m_fault = 1'b0;
      end
    end else begin
      if (pop) q.delete(0);
      if (!m_fault) begin
        if (m_pc < ROM_BYTES) begin
          // After the pop, a free slot exists iff count < DEPTH or a pop happened.
          if (q.size() < DEPTH) begin
            q.push_back({m_pc, rom[m_pc[6:2]]});
            m_pc = m_pc + 32'd4;
          end
        end else begin
          m_fault = 1'b1;
          m_fpc   = m_pc;
        end
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check_all("reset");
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] tgt;
    int r;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    for (int i = 0; i < int'(ROM_WORDS); i++) rom[i] = $urandom;
    rom[0] = 32'h0000_0000;
    rom[1] = 32'h02A0_0093;
    rom[2] = 32'h02A0_8093;
    model_reset();

    // Reset values, then one edge to first valid, streaming at full rate.
    do_reset();
    check("rst.out_valid", {31'b0, out_valid}, 32'd0);
    check("rst.imem_addr", imem_addr, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, "stream");

    // Backpressure from reset: buffer holds 0x0/0x4, address parks at 0x8.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, "stall");
    check("stall.imem_addr", imem_addr, 32'h8);
    check("stall.head", out_pc, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, "release");

    // Redirect with a full buffer: one bubble, then target stream.
    do_reset();
    step(1'b0, 32'h0, 1'b0, "fill");
    step(1'b0, 32'h0, 1'b0, "fill");
    step(1'b1, 32'h10, 1'b0, "redir");
    check("redir.bubble", {31'b0, out_valid}, 32'd0);
    step(1'b0, 32'h0, 1'b1, "redir_tgt");
    check("redir.first_pc", out_pc, 32'h10);
    step(1'b0, 32'h0, 1'b1, "redir_tgt");

    // Misaligned redirect faults; aligned redirect recovers.
    step(1'b1, 32'h12, 1'b1, "misal");
    check("misal.fault_pc", fault_pc, 32'h12);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, "misal_hold");
    check("misal.imem_addr", imem_addr, 32'h12);
    step(1'b1, 32'h0, 1'b1, "recover");
    step(1'b0, 32'h0, 1'b1, "recover_run");
    check("recover.out_pc", out_pc, 32'h0);

    // Free run off the end of the ROM.
    step(1'b1, 32'h0, 1'b1, "freerun");
    for (int i = 0; i < 45 && !(m_fault && q.size() == 0); i++) step(1'b0, 32'h0, 1'b1, "freerun");
    check("end.fault", {31'b0, fault}, 32'd1);
    check("end.fault_pc", fault_pc, 32'h80);
    check("end.out_valid", {31'b0, out_valid}, 32'd0);

    // Randomised ready and redirects.
    step(1'b1, 32'h0, 1'b0, "rand_start");
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 19);
      if (r < 17) begin
        step(1'b0, 32'h0, 1'($urandom_range(0, 1)), "rand");
      end else begin
        r = $urandom_range(0, 9);
        if (r < 6)      tgt = 32'($urandom_range(0, 31)) * 32'd4;
        else if (r < 8) tgt = (32'($urandom_range(0, 31)) * 32'd4) | 32'($urandom_range(1, 3));
        else            tgt = ROM_BYTES - 32'd8 + 32'($urandom_range(0, 4)) * 32'd4;
        step(1'b1, tgt, 1'($urandom_range(0, 1)), "rand_redir");
      end
    end

    // Asynchronous reset mid-run with a non-empty buffer.
    step(1'b1, 32'h20, 1'b0, "pre_arst");
    step(1'b0, 32'h0, 1'b0, "pre_arst");
    step(1'b0, 32'h0, 1'b0, "pre_arst");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst.out_valid", {31'b0, out_valid}, 32'd0);
    check("arst.fault", {31'b0, fault}, 32'd0);
    check("arst.fault_pc", fault_pc, 32'h0);
    check("arst.imem_addr", imem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, "post_arst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the instruction ROM and downstream of the branch/jump redirect logic.
- Holds the PC and drives the ROM address.
- Captures the combinational ROM read data into a small instruction buffer.
- Presents {pc, instr} to decode over a valid/ready handshake.
- Flags fetch faults for misaligned targets and out-of-range addresses.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ROM_WORDS, 32, number of 32-bit words in the instruction ROM; legal fetch range is [0, ROM_WORDS*4).
- DEPTH, 2, instruction buffer entries; power of two, >= 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- imem_addr  output  32  byte address to ROM; ROM returns data combinationally in the same cycle.
- imem_data  input  32  instruction word at imem_addr.
- redirect_valid  input  1  load a new PC this cycle (branch/jump taken).
- redirect_pc  input  32  redirect target byte address.
- out_valid  output  1  buffer head holds a valid instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_instr  output  32  instruction at buffer head.
- out_pc  output  32  PC of out_instr.
- fault  output  1  fetch halted on fault; held until the next redirect.
- fault_pc  output  32  address that caused the fault.

Behaviour:
- Interface timing: one clock, clk; rst is asynchronous and active-high. All state is cleared immediately on rst assertion, independent of clk.
- Reset values:
  - pc = RESET_PC, buffer empty (count 0), state RUN.
  - out_valid = 0, fault = 0, fault_pc = 0.
  - imem_addr = RESET_PC.
- Address output: imem_addr = pc, combinational from the PC register.
- States:
  - RUN: fetching.
  - FAULT: fetching stopped; fault = 1.
- Pop: occurs when out_valid && out_ready at a rising edge.
- Push (RUN only): at a rising edge, when pc < ROM_WORDS*4 and (count < DEPTH or pop this cycle):
  - Write {pc, imem_data} at the buffer tail.
  - pc <= pc + 4, 32-bit modular.
- Full and pop in the same cycle: push and pop both occur; count unchanged. This gives a sustained throughput of 1 instruction/cycle.
- Full and no pop: no push; pc holds; imem_addr stable.
- Range fault: in RUN with pc >= ROM_WORDS*4 at an edge:
  - No push; state <= FAULT; fault_pc <= pc.
  - Entries already buffered still drain normally.
- FAULT state: no pushes; pc holds. Pops continue until the buffer is empty, then out_valid = 0.
- Redirect: redirect_valid at an edge has highest priority, in any state.
  - Buffer flushed (count <= 0); any push that cycle is discarded.
  - A pop that cycle still counts as consumed by decode.
  - If redirect_pc[1:0] != 0: state <= FAULT, fault_pc <= redirect_pc, pc <= redirect_pc.
  - Otherwise: state <= RUN, fault <= 0, pc <= redirect_pc.
- Latency:
  - Reset release to first out_valid: 1 edge.
  - Redirect edge to first valid target instruction: 1 further edge. out_valid is low for exactly one cycle after the redirect edge.
- Outputs out_instr and out_pc are read from the buffer head register. They are don't-care when out_valid = 0.
- Buffer pointers wrap modulo DEPTH. count ranges 0..DEPTH and never overflows or underflows.
- No instruction is duplicated or dropped across backpressure. Order is strictly by increasing pc between redirects.

Test Plan:
- Reset, out_ready=1, bench ROM with word0=0x00000000, word1=0x02A00093, word2=0x02A08093 -> out_valid rises 1 edge after reset release; out_pc = 0x0, 0x4, 0x8 on consecutive cycles with the matching instrs.
- out_ready=0 for 5 cycles from reset (DEPTH=2) -> buffer holds pc 0x0 and 0x4; imem_addr stays 0x8. On release, out_pc = 0x0, 0x4, 0x8, 0xC with no gaps, duplicates or loss.
- Buffer full (0x0, 0x4), redirect_pc=0x10 -> out_valid=0 for one cycle, then out_pc=0x10, 0x14. Entries 0x0 and 0x4 are never presented.
- Redirect to 0x12 -> fault=1, fault_pc=0x12, out_valid=0, imem_addr holds 0x12. A later redirect to 0x0 -> fault=0, out_pc=0x0 on the following cycle.
- ROM_WORDS=32, free run from 0 -> last out_pc=0x7C; then fault=1, fault_pc=0x80, out_valid=0 after drain.
- Assert rst between edges mid-run with buffer non-empty -> out_valid, fault and fault_pc go to 0 and imem_addr to 0x0 without waiting for a clk edge. After release, the sequence restarts at 0x0.
